ssd_scan_ctrl: RTL

- Consumer end of the display-clock interface: takes the divided display clock `dclk` (bit 15 of the display clock divider) and scans a 4-digit common-anode seven-segment display.
- Time-multiplexes a 16-bit hex value onto shared cathodes with active-low anode selects.
- Sits between the sensor/accumulator datapath (value source) and the board display pins.

---
 rtl/ssd_pkg.sv | 31 +++
 rtl/ssd_hex_decoder.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: digit count, idle drive levels
// and the active-low hex-to-segment table ({g,f,e,d,c,b,a}).
package ssd_pkg;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Entry n is the pattern for nibble n; b and d are lowercase glyphs.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, // F
        7'b0000110, // E
        7'b0100001, // d
        7'b1000110, // C
        7'b0000011, // b
        7'b0001000, // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode display scanner stepped by a synchronised divided clock.
// Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module ssd_scan_ctrl #(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned GHOST_CYC = 8
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        dclk,
    input  logic        EN,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP_MASK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);
    import ssd_pkg::*;

    localparam int unsigned BLK_W = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic             s1_d, s1_q, s2_d, s2_q, dly_d, dly_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [BLK_W-1:0] blk_d, blk_q;
    logic [15:0]      val_d, val_q;
    logic [3:0]       mask_d, mask_q;
    logic [3:0]       an_d, an_q;
    logic [6:0]       seg_d, seg_q;
    logic             dp_d, dp_q;
    logic             step;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic             lz_blank;

    assign step = s2_q & ~dly_q;
    assign nib  = val_q[{idx_q, 2'b00} +: 4];

    ssd_hex_decoder u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    assign lz_blank = (idx_q != '0) && ((val_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        s1_d   = dclk;
        s2_d   = s1_q;
        dly_d  = s2_q;
        idx_d  = idx_q;
        blk_d  = blk_q;
        val_d  = val_q;
        mask_d = mask_q;
        if (step) begin
            blk_d = BLK_LOAD;
            if (idx_q == IDX_LAST) begin
                // Shadow the value only at scan wrap so one scan never mixes two values.
                idx_d  = '0;
                val_d  = VALUE;
                mask_d = DP_MASK;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (blk_q != '0) begin
            blk_d = blk_q - 1'b1;
        end
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (EN && (blk_q == '0)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? SEG_OFF : dec_seg;
            dp_d  = ~mask_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            dly_q  <= 1'b0;
            idx_q  <= '0;
            blk_q  <= '0;
            val_q  <= 16'h0000;
            mask_q <= 4'h0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            dly_q  <= dly_d;
            idx_q  <= idx_d;
            blk_q  <= blk_d;
            val_q  <= val_d;
            mask_q <= mask_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule
